// File: rtl/wf_done_collector.sv
// Collects per-warp completion tags through a round-robin arbiter into a small
// FIFO that the CTA scheduler drains over a valid/ready handshake.
module wf_done_collector #(
   parameter int NUM_WARP   = 8,
   parameter int TAG_WIDTH  = 8,
   parameter int FIFO_DEPTH = 4,
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_WARP-1:0]           warp_done_valid_i,
   input  logic [NUM_WARP*TAG_WIDTH-1:0] warp_done_tag_i,
   output logic [NUM_WARP-1:0]           warp_done_ready_o,
   output logic                          warp2cta_valid_o,
   input  logic                          warp2cta_ready_i,
   output logic [TAG_WIDTH-1:0]          warp2cta_wf_tag_done_o,
   output logic [CNT_W-1:0]              fifo_count_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int RR_W  = (NUM_WARP > 1) ? $clog2(NUM_WARP) : 1;
   localparam logic [RR_W:0]    NUM_WARP_C = (RR_W + 1)'(NUM_WARP);
   localparam logic [RR_W-1:0]  LAST_WARP  = RR_W'(NUM_WARP - 1);
   localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);

   logic [RR_W-1:0]      rr_q, rr_d;
   logic [PTR_W-1:0]     wr_q, wr_d;
   logic [PTR_W-1:0]     rd_q, rd_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [TAG_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic                 grant_found;
   logic [RR_W-1:0]      grant_idx;
   logic [NUM_WARP-1:0]  grant_onehot;
   logic [TAG_WIDTH-1:0] grant_tag;
   logic                 fifo_space;
   logic                 push;
   logic                 pop;

   assign warp2cta_valid_o       = (count_q != '0);
   assign warp2cta_wf_tag_done_o = mem_q[rd_q];
   assign fifo_count_o           = count_q;

   assign pop        = warp2cta_valid_o && warp2cta_ready_i;
   assign fifo_space = (count_q < DEPTH_C) || pop;

   // Round-robin search: first valid warp at or after rr_q, wrapping past the last warp.
   always_comb begin
      logic [RR_W:0] cand;
      cand        = '0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_WARP; k++) begin
         cand = {1'b0, rr_q} + (RR_W + 1)'(k);
         if (cand >= NUM_WARP_C) begin
            cand = cand - NUM_WARP_C;
         end
         if (!grant_found && warp_done_valid_i[cand[RR_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[RR_W-1:0];
         end
      end
   end

   always_comb begin
      grant_onehot = '0;
      grant_tag    = '0;
      for (int w = 0; w < NUM_WARP; w++) begin
         if (grant_idx == RR_W'(w)) begin
            grant_onehot[w] = 1'b1;
            grant_tag       = warp_done_tag_i[w*TAG_WIDTH +: TAG_WIDTH];
         end
      end
   end

   // Ready is forced low while reset is held so no warp sees a phantom acceptance.
   always_comb begin
      push              = grant_found && fifo_space && rst_n;
      warp_done_ready_o = push ? grant_onehot : '0;
   end

   always_comb begin
      rr_d    = rr_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (push) begin
         rr_d = (grant_idx == LAST_WARP) ? '0 : grant_idx + 1'b1;
         wr_d = wr_q + 1'b1;
      end
      if (pop) begin
         rd_d = rd_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q    <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         rr_q    <= rr_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   // Tag storage carries no reset; occupancy alone decides what is meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_q] <= grant_tag;
      end
   end

endmodule

// File: tb/tb_wf_done_collector.sv
// Directed scoreboard bench for wf_done_collector: stimulus pushes expected tags,
// a negedge monitor pops and compares every tag the DUT hands to the CTA side.
module tb_wf_done_collector;

   localparam int NW = 8;
   localparam int TW = 8;
   localparam int FD = 4;
   localparam int CW = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NW-1:0]    valid;
   logic [NW*TW-1:0] tags;
   logic [NW-1:0]    ready_o;
   logic             wc_valid;
   logic             wc_ready;
   logic [TW-1:0]    tag_o;
   logic [CW-1:0]    count;

   int            n_checks = 0;
   int            n_pass   = 0;
   logic [TW-1:0] sb_q [$];
   logic [TW-1:0] mon_exp;
   logic [NW-1:0] v;
   int            sent;
   int            cyc;
   int            w;

   wf_done_collector #(.NUM_WARP(NW), .TAG_WIDTH(TW), .FIFO_DEPTH(FD)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .warp_done_valid_i      (valid),
      .warp_done_tag_i        (tags),
      .warp_done_ready_o      (ready_o),
      .warp2cta_valid_o       (wc_valid),
      .warp2cta_ready_i       (wc_ready),
      .warp2cta_wf_tag_done_o (tag_o),
      .fifo_count_o           (count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual === expected) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic applyStimulus(input logic [NW-1:0] vin, input logic rin);
      @(posedge clk);
      #1;
      valid    = vin;
      wc_ready = rin;
   endtask

   task automatic set_tag(input int idx, input logic [TW-1:0] t);
      tags[idx*TW +: TW] = t;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      valid    = '0;
      wc_ready = 1'b0;
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input int budget);
      int c;
      c = 0;
      while (sb_q.size() != 0 && c < budget) begin
         @(posedge clk);
         c++;
      end
      checkOutput("drain_within_budget", sb_q.size(), 0);
      @(negedge clk);
      checkOutput("count_after_drain", count, 0);
   endtask

   // Scoreboard monitor plus the full-without-pop and empty-valid invariants.
   always @(negedge clk) begin
      if (rst_n && wc_valid && wc_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL unexpected_tag: got 0x%0h, expected none", tag_o);
         end else begin
            mon_exp = sb_q.pop_front();
            checkOutput("scoreboard_tag", tag_o, mon_exp);
         end
      end
      if (rst_n && count == CW'(FD) && !(wc_valid && wc_ready))
         checkOutput("full_no_grant", ready_o, 0);
      if (rst_n && count == '0)
         checkOutput("empty_no_valid", wc_valid, 0);
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n    = 1'b0;
      valid    = 8'h08;
      tags     = '0;
      wc_ready = 1'b0;
      @(negedge clk);
      checkOutput("reset_valid_o", wc_valid, 0);
      checkOutput("reset_ready_o", ready_o, 0);
      checkOutput("reset_count", count, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      valid = '0;

      // Single done on warp 3
      set_tag(3, 8'h15);
      applyStimulus(8'h08, 1'b1);
      @(negedge clk);
      checkOutput("single_ready", ready_o, 8'h08);
      checkOutput("single_no_bypass", wc_valid, 0);
      sb_q.push_back(8'h15);
      applyStimulus(8'h00, 1'b1);
      @(negedge clk);
      checkOutput("single_valid_o", wc_valid, 1);
      checkOutput("single_tag", tag_o, 8'h15);
      checkOutput("single_count", count, 1);
      applyStimulus(8'h00, 1'b1);
      @(negedge clk);
      checkOutput("single_count_after_pop", count, 0);

      // Round robin over warps 0, 2, 5
      do_reset();
      set_tag(0, 8'hA0);
      set_tag(2, 8'hA2);
      set_tag(5, 8'hA5);
      applyStimulus(8'h25, 1'b1);
      @(negedge clk);
      checkOutput("rr_grant0", ready_o, 8'h01);
      sb_q.push_back(8'hA0);
      applyStimulus(8'h24, 1'b1);
      @(negedge clk);
      checkOutput("rr_grant1", ready_o, 8'h04);
      sb_q.push_back(8'hA2);
      applyStimulus(8'h20, 1'b1);
      @(negedge clk);
      checkOutput("rr_grant2", ready_o, 8'h20);
      sb_q.push_back(8'hA5);
      applyStimulus(8'h00, 1'b1);
      @(negedge clk);
      checkOutput("rr_count_tail", count, 1);
      wait_drain(10);

      // Fill to full with the scheduler stalled
      do_reset();
      for (int i = 0; i < NW; i++) set_tag(i, 8'(8'hB0 + i));
      v = 8'hFF;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(v, 1'b0);
         @(negedge clk);
         checkOutput("fill_grant", ready_o, 32'(8'(1 << k)));
         sb_q.push_back(8'(8'hB0 + k));
         v[k] = 1'b0;
      end
      applyStimulus(v, 1'b0);
      @(negedge clk);
      checkOutput("full_ready_zero", ready_o, 0);
      checkOutput("full_count", count, 4);
      checkOutput("full_valid_o", wc_valid, 1);
      checkOutput("full_head", tag_o, 8'hB0);
      applyStimulus(v, 1'b0);
      @(negedge clk);
      checkOutput("full_head_hold", tag_o, 8'hB0);

      // Full with simultaneous pop admits warp 6
      applyStimulus(8'h40, 1'b1);
      @(negedge clk);
      checkOutput("full_pop_grant", ready_o, 8'h40);
      checkOutput("full_pop_count", count, 4);
      sb_q.push_back(8'hB6);
      applyStimulus(8'h00, 1'b0);
      @(negedge clk);
      checkOutput("full_pop_count_after", count, 4);
      checkOutput("full_pop_head_advanced", tag_o, 8'hB1);
      applyStimulus(8'h00, 1'b1);
      wait_drain(10);

      // Ten tags through the depth-4 FIFO with random back-pressure
      do_reset();
      sent = 0;
      cyc  = 0;
      while (sent < 10 && cyc < 300) begin
         w = sent % NW;
         v = 8'(1 << w);
         set_tag(w, 8'(sent));
         applyStimulus(v, 1'($urandom_range(0, 1)));
         @(negedge clk);
         if (ready_o != '0) begin
            checkOutput("wrap_grant", ready_o, 32'(v));
            if (ready_o == v) begin
               sb_q.push_back(8'(sent));
               sent++;
            end
         end
         cyc++;
      end
      checkOutput("wrap_all_sent", sent, 10);
      applyStimulus(8'h00, 1'b1);
      wait_drain(20);

      // Reset in the middle of traffic
      do_reset();
      set_tag(1, 8'hC1);
      set_tag(2, 8'hC2);
      set_tag(3, 8'hC3);
      v = 8'h0E;
      for (int k = 1; k < 4; k++) begin
         applyStimulus(v, 1'b0);
         @(negedge clk);
         checkOutput("pre_reset_grant", ready_o, 32'(8'(1 << k)));
         sb_q.push_back(8'(8'hC0 + k));
         v[k] = 1'b0;
      end
      applyStimulus(8'h00, 1'b0);
      @(negedge clk);
      checkOutput("pre_reset_count", count, 3);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb_q.delete();
      set_tag(0, 8'hD0);
      set_tag(7, 8'hD7);
      valid = 8'h81;
      @(negedge clk);
      checkOutput("mid_reset_ready", ready_o, 0);
      checkOutput("mid_reset_valid_o", wc_valid, 0);
      checkOutput("mid_reset_count", count, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_reset_valid_o", wc_valid, 0);
      checkOutput("post_reset_count", count, 0);
      checkOutput("post_reset_grant", ready_o, 8'h01);
      sb_q.push_back(8'hD0);
      applyStimulus(8'h00, 1'b1);
      wait_drain(10);

      checkOutput("scoreboard_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
